// File: rtl/pc_file_read_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// pc_file_read_arbiter_pkg
//   Shared types and constants for the PC file read-port arbiter.
//   - PCFileArbReq_t  : one requester's view {valid, prio, addr}
//   - PCFileArbResp_t : response view {valid, data}
//   - PCF_ARB_AGE_W   : width of the per-requester age counter that is used
//                       when PCFILE_ARB_AGING_EN is defined
//   - pcf_arb_rr_next : round-robin pointer advance with wrap
// ----------------------------------------------------------------------------
package pc_file_read_arbiter_pkg;

    localparam int PCF_ARB_NUM_REQ = 3;
    localparam int PCF_ARB_ADDR_W  = 5;   // = $bits(FetchID_t)
    localparam int PCF_ARB_DATA_W  = 64;  // = $bits(PCFileEntry)
    localparam int PCF_ARB_AGE_MAX = 7;
    localparam int PCF_ARB_AGE_W   = $clog2(PCF_ARB_AGE_MAX + 1);

    typedef struct packed {
        logic                      valid;
        logic                      prio;
        logic [PCF_ARB_ADDR_W-1:0] addr;
    } PCFileArbReq_t;

    typedef struct packed {
        logic                      valid;
        logic [PCF_ARB_DATA_W-1:0] data;
    } PCFileArbResp_t;

    // Next round-robin start position: one past the winner, wrapping to 0.
    function automatic int unsigned pcf_arb_rr_next(input int unsigned idx,
                                                    input int unsigned num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pc_file_read_arbiter_if.sv
// ----------------------------------------------------------------------------
// pc_file_read_arbiter_if
//   Bundles the requester handshake, the PC file read/write port and the
//   response strobe of the PC file read arbiter.
//   master : requesters + PC file (drive IN_*, observe OUT_*)
//   slave  : the arbiter          (observe IN_*, drive OUT_*)
//   Signals:
//     IN_reqValid / IN_reqPrio / IN_reqAddr  per-requester request
//     OUT_reqReady                           one-hot grant
//     OUT_re / OUT_raddr / IN_rdata          PC file synchronous read port
//     IN_we / IN_waddr / IN_wdata            snooped PC file write port
//     OUT_respValid / OUT_respData           one-hot response + data
// ----------------------------------------------------------------------------
interface pc_file_read_arbiter_if
    import pc_file_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = PCF_ARB_NUM_REQ,
    parameter int ADDR_W  = PCF_ARB_ADDR_W,
    parameter int DATA_W  = PCF_ARB_DATA_W
);
    logic [NUM_REQ-1:0]        IN_reqValid;
    logic [NUM_REQ-1:0]        IN_reqPrio;
    logic [NUM_REQ*ADDR_W-1:0] IN_reqAddr;
    logic [NUM_REQ-1:0]        OUT_reqReady;
    logic                      OUT_re;
    logic [ADDR_W-1:0]         OUT_raddr;
    logic [DATA_W-1:0]         IN_rdata;
    logic                      IN_we;
    logic [ADDR_W-1:0]         IN_waddr;
    logic [DATA_W-1:0]         IN_wdata;
    logic [NUM_REQ-1:0]        OUT_respValid;
    logic [DATA_W-1:0]         OUT_respData;

    modport master (
        output IN_reqValid, IN_reqPrio, IN_reqAddr, IN_rdata, IN_we, IN_waddr, IN_wdata,
        input  OUT_reqReady, OUT_re, OUT_raddr, OUT_respValid, OUT_respData
    );

    modport slave (
        input  IN_reqValid, IN_reqPrio, IN_reqAddr, IN_rdata, IN_we, IN_waddr, IN_wdata,
        output OUT_reqReady, OUT_re, OUT_raddr, OUT_respValid, OUT_respData
    );

endinterface

// File: rtl/pc_file_read_arbiter_rr_pick_onehot.sv
// ----------------------------------------------------------------------------
// rr_pick_onehot
//   Rotating first-set-bit finder. Searches IN_mask starting at IN_ptr and
//   moving upward, wrapping from NUM-1 to 0.
//   Ports:
//     IN_mask    candidate bits
//     IN_ptr     search start position (< NUM)
//     OUT_onehot one-hot of the first candidate found (0 if IN_mask == 0)
//     OUT_idx    index of that candidate (0 if IN_mask == 0)
// ----------------------------------------------------------------------------
module rr_pick_onehot #(
    parameter  int NUM   = 3,
    localparam int PTR_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]   IN_mask,
    input  logic [PTR_W-1:0] IN_ptr,
    output logic [NUM-1:0]   OUT_onehot,
    output logic [PTR_W-1:0] OUT_idx
);

    logic found;
    int   pos;

    always_comb begin
        // NOTE: every variable assigned here gets a default before the loop,
        // so no path leaves a value held over and no latch is inferred.
        OUT_onehot = '0;
        OUT_idx    = '0;
        found      = 1'b0;
        pos        = 0;
        for (int i = 0; i < NUM; i++) begin
            // IN_ptr + i < 2*NUM, so one conditional subtract wraps it.
            pos = int'(IN_ptr) + i;
            if (pos >= NUM) pos = pos - NUM;
            if (!found && IN_mask[pos]) begin
                found           = 1'b1;
                OUT_onehot[pos] = 1'b1;
                OUT_idx         = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/pc_file_read_arbiter.sv
// ----------------------------------------------------------------------------
// pc_file_read_arbiter
//   Shares the single synchronous read port of the PC file among NUM_REQ
//   requesters (branch ports, trap handler, BP). High-priority class first,
//   round-robin inside the class. Data returns one cycle after the grant;
//   a PC file write to the granted address in the grant cycle is bypassed.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     bus  pc_file_read_arbiter_if.slave (requests, PC file port, responses)
//   Optional feature: define PCFILE_ARB_AGING_EN to add per-requester age
//   counters that promote a starving low-priority requester into the high
//   class after AGE_MAX stalled cycles. AGE_MAX must fit in PCF_ARB_AGE_W.
// ----------------------------------------------------------------------------
module pc_file_read_arbiter
    import pc_file_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = PCF_ARB_NUM_REQ,
    parameter int ADDR_W  = PCF_ARB_ADDR_W,
    parameter int DATA_W  = PCF_ARB_DATA_W
`ifdef PCFILE_ARB_AGING_EN
   ,parameter int AGE_MAX = PCF_ARB_AGE_MAX
`endif
) (
    input logic                   clk,
    input logic                   rst,
    pc_file_read_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    PCFileArbReq_t      req [NUM_REQ];
    logic [NUM_REQ-1:0] valid_vec;
    logic [NUM_REQ-1:0] promoted;
    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] elig_mask;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [PTR_W-1:0]   winner_idx;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]  raddr;
    logic               grant;
    logic               bypass_hit;

    logic               resp_valid_q;
    logic [PTR_W-1:0]   resp_idx_q;
    logic               bypass_hit_q;
    logic [DATA_W-1:0]  bypass_data_q;
    PCFileArbResp_t     resp;

    // ------------------------------------------------------------------
    // Request unpacking and class selection
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].valid = bus.IN_reqValid[i];
            req[i].prio  = bus.IN_reqPrio[i];
            req[i].addr  = bus.IN_reqAddr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_vec[i] = req[i].valid;
            hi_mask[i]   = req[i].valid && (req[i].prio || promoted[i]);
        end
        // With nobody in the high class, everybody valid competes.
        elig_mask = (hi_mask != '0) ? hi_mask : valid_vec;
    end

    rr_pick_onehot #(.NUM(NUM_REQ)) u_pick (
        .IN_mask    (elig_mask),
        .IN_ptr     (rr_ptr_q),
        .OUT_onehot (pick_onehot),
        .OUT_idx    (winner_idx)
    );

    // ------------------------------------------------------------------
    // Grant, read port drive, bypass detection
    // ------------------------------------------------------------------
    always_comb begin
        grant_onehot = '0;
        grant        = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        raddr        = req[winner_idx].addr;
        // No grants while reset is asserted, so the reset state is quiet.
        if (!rst) begin
            grant_onehot = pick_onehot;
            grant        = |pick_onehot;
        end
        if (grant) rr_ptr_d = PTR_W'(pcf_arb_rr_next(32'(winner_idx), unsigned'(NUM_REQ)));
        // The PC file returns the pre-write value on a same-cycle collision.
        bypass_hit = grant && bus.IN_we && (bus.IN_waddr == raddr);
    end

    assign bus.OUT_reqReady = grant_onehot;
    assign bus.OUT_re       = grant;
    assign bus.OUT_raddr    = raddr;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
            bypass_hit_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= grant;
            resp_idx_q   <= winner_idx;
            bypass_hit_q <= bypass_hit;
        end
    end

    // NOTE: bypass data is pure datapath qualified by bypass_hit_q, so it
    // carries no reset and only loads on a hit.
    always_ff @(posedge clk) begin
        if (bypass_hit) bypass_data_q <= bus.IN_wdata;
    end

    // ------------------------------------------------------------------
    // Response: one cycle after grant; a reset arriving in that cycle
    // cancels the in-flight response.
    // ------------------------------------------------------------------
    always_comb begin
        resp.valid        = resp_valid_q && !rst;
        resp.data         = bypass_hit_q ? bypass_data_q : bus.IN_rdata;
        bus.OUT_respValid = '0;
        if (resp.valid) bus.OUT_respValid[resp_idx_q] = 1'b1;
        bus.OUT_respData  = resp.data;
    end

    // ------------------------------------------------------------------
    // Optional aging: a low-priority requester stalled for AGE_MAX cycles
    // is promoted into the high class; ties then fall to rr_ptr_q.
    // ------------------------------------------------------------------
`ifdef PCFILE_ARB_AGING_EN
    logic [PCF_ARB_AGE_W-1:0] age_q [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i].valid || grant_onehot[i]) begin
                    age_q[i] <= '0;
                end else if (!req[i].prio && (age_q[i] != PCF_ARB_AGE_W'(AGE_MAX))) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            promoted[i] = (age_q[i] == PCF_ARB_AGE_W'(AGE_MAX));
        end
    end
`else
    // Strict class priority: low-priority requesters may starve.
    assign promoted = '0;
`endif

endmodule

// File: tb/tb_pc_file_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pc_file_read_arbiter
//   Directed bench for pc_file_read_arbiter. Includes a small PC file
//   (synchronous read, read-before-write) driven from the arbiter's read
//   port and the bench's write port.
// ----------------------------------------------------------------------------
module tb_pc_file_read_arbiter;
    import pc_file_read_arbiter_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 64;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] pcmem [2**ADDR_W];
    logic [DATA_W-1:0] rr_data [NUM_REQ] = '{64'h1001, 64'h2002, 64'h4004};

    pc_file_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pc_file_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // PC file: old data on a same-cycle read/write collision.
    always @(posedge clk) begin
        if (bus.IN_we)  pcmem[bus.IN_waddr] <= bus.IN_wdata;
        if (bus.OUT_re) bus.IN_rdata <= pcmem[bus.OUT_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.IN_reqValid = '0;
        bus.IN_reqPrio  = '0;
        bus.IN_reqAddr  = '0;
        bus.IN_we       = 1'b0;
        bus.IN_waddr    = '0;
        bus.IN_wdata    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic prio, input logic [ADDR_W-1:0] addr);
        bus.IN_reqValid[i]                 = 1'b1;
        bus.IN_reqPrio[i]                  = prio;
        bus.IN_reqAddr[i*ADDR_W +: ADDR_W] = addr;
    endtask

    task automatic write_pc(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.IN_we    = 1'b1;
        bus.IN_waddr = a;
        bus.IN_wdata = d;
        tick();
        bus.IN_we    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.OUT_re !== 1'b0) begin
                errors++; $display("FAIL reset_re cyc%0d: got %b want 0", c, bus.OUT_re);
            end
            checks++;
            if (bus.OUT_respValid !== 3'b000) begin
                errors++; $display("FAIL reset_respValid cyc%0d: got %b want 000", c, bus.OUT_respValid);
            end
            checks++;
            if (bus.OUT_reqReady !== 3'b000) begin
                errors++; $display("FAIL reset_reqReady cyc%0d: got %b want 000", c, bus.OUT_reqReady);
            end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1'b0, 5'd3);
        @(negedge clk);
        checks++;
        if (bus.OUT_reqReady !== 3'b001) begin
            errors++; $display("FAIL single_ready: got %b want 001", bus.OUT_reqReady);
        end
        checks++;
        if (bus.OUT_re !== 1'b1 || bus.OUT_raddr !== 5'd3) begin
            errors++; $display("FAIL single_read: got re=%b raddr=%0d want re=1 raddr=3", bus.OUT_re, bus.OUT_raddr);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (bus.OUT_respValid !== 3'b001) begin
            errors++; $display("FAIL single_respValid: got %b want 001", bus.OUT_respValid);
        end
        checks++;
        if (bus.OUT_respData !== 64'hAB) begin
            errors++; $display("FAIL single_respData: got %h want ab", bus.OUT_respData);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.OUT_respValid !== 3'b000) begin
            errors++; $display("FAIL single_noresp: got %b want 000", bus.OUT_respValid);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp;
        do_reset();
        set_req(0, 1'b0, 5'd1);
        set_req(1, 1'b0, 5'd2);
        set_req(2, 1'b0, 5'd4);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = 3'(1 << (k % 3));
            checks++;
            if (bus.OUT_reqReady !== exp) begin
                errors++; $display("FAIL rr_ready k%0d: got %b want %b", k, bus.OUT_reqReady, exp);
            end
            if (k > 0) begin
                exp = 3'(1 << ((k - 1) % 3));
                checks++;
                if (bus.OUT_respValid !== exp) begin
                    errors++; $display("FAIL rr_respValid k%0d: got %b want %b", k, bus.OUT_respValid, exp);
                end
                checks++;
                if (bus.OUT_respData !== rr_data[(k - 1) % 3]) begin
                    errors++; $display("FAIL rr_respData k%0d: got %h want %h", k, bus.OUT_respData, rr_data[(k - 1) % 3]);
                end
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.OUT_respValid !== 3'b100 || bus.OUT_respData !== 64'h4004) begin
            errors++; $display("FAIL rr_last_resp: got %b/%h want 100/4004", bus.OUT_respValid, bus.OUT_respData);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [NUM_REQ-1:0] exp;
        do_reset();
        set_req(0, 1'b0, 5'd1);
        set_req(1, 1'b1, 5'd2);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef PCFILE_ARB_AGING_EN
            // req0 waits 7 cycles, is promoted on the 8th and wins the tie.
            exp = ((k % 8) == 7) ? 3'b001 : 3'b010;
`else
            exp = 3'b010;
`endif
            checks++;
            if (bus.OUT_reqReady !== exp) begin
                errors++; $display("FAIL prio_ready k%0d: got %b want %b", k, bus.OUT_reqReady, exp);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        do_reset();
        set_req(2, 1'b0, 5'd9);
        bus.IN_we    = 1'b1;
        bus.IN_waddr = 5'd9;
        bus.IN_wdata = 64'h55;
        @(negedge clk);
        checks++;
        if (bus.OUT_reqReady !== 3'b100 || bus.OUT_raddr !== 5'd9) begin
            errors++; $display("FAIL bypass_grant: got %b/%0d want 100/9", bus.OUT_reqReady, bus.OUT_raddr);
        end
        tick();
        // Write to the same address in the response cycle must not leak in.
        bus.IN_reqValid = '0;
        bus.IN_wdata    = 64'h77;
        @(negedge clk);
        checks++;
        if (bus.OUT_respValid !== 3'b100) begin
            errors++; $display("FAIL bypass_respValid: got %b want 100", bus.OUT_respValid);
        end
        checks++;
        if (bus.OUT_respData !== 64'h55) begin
            errors++; $display("FAIL bypass_respData: got %h want 55", bus.OUT_respData);
        end
        tick();
        bus.IN_we = 1'b0;
        set_req(2, 1'b0, 5'd9);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (bus.OUT_respValid !== 3'b100 || bus.OUT_respData !== 64'h77) begin
            errors++; $display("FAIL bypass_reread: got %b/%h want 100/77", bus.OUT_respValid, bus.OUT_respData);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_req(1, 1'b0, 5'd2);
        @(negedge clk);
        checks++;
        if (bus.OUT_reqReady !== 3'b010) begin
            errors++; $display("FAIL inflight_grant: got %b want 010", bus.OUT_reqReady);
        end
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.OUT_respValid !== 3'b000) begin
            errors++; $display("FAIL inflight_suppress: got %b want 000", bus.OUT_respValid);
        end
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 5'd1);
        set_req(1, 1'b0, 5'd2);
        set_req(2, 1'b0, 5'd4);
        @(negedge clk);
        checks++;
        if (bus.OUT_reqReady !== 3'b001) begin
            errors++; $display("FAIL inflight_rrptr: got %b want 001", bus.OUT_reqReady);
        end
        tick();
        idle();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        write_pc(5'd3, 64'hAB);
        write_pc(5'd1, 64'h1001);
        write_pc(5'd2, 64'h2002);
        write_pc(5'd4, 64'h4004);
        write_pc(5'd9, 64'h11);
        test_single();
        test_round_robin();
        test_priority();
        test_bypass();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
